// File: rtl/dct2_pkg.sv
// Shared types and helpers for the 2D DCT-II block sequencer.
// Holds the sequencer state encoding, the supported block-size range
// and the block-size clamp used when a start request is accepted.
package dct2_pkg;

  localparam int LOG2_MIN = 2;
  localparam int LOG2_MAX = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    H       = 3'd1,
    H_DRAIN = 3'd2,
    V       = 3'd3,
    V_DRAIN = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Clamp a requested log2 block size into [LOG2_MIN, hi].
  function automatic logic [2:0] clamp_log2(input logic [2:0] req, input logic [2:0] hi);
    logic [2:0] res;
    if (req < 3'(LOG2_MIN)) begin
      res = 3'(LOG2_MIN);
    end else if (req > hi) begin
      res = hi;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/dct2_seq_delay.sv
// Issue-to-result delay line for the 1D core.
// Carries {valid, direction, index} of every issued row/column through
// CORE_LAT register stages so the result bookkeeping lines up with the
// core output: horizontal results become transpose-buffer writes,
// vertical results become final columns for downstream.
module dct2_seq_delay #(
  parameter int CORE_LAT = 2,
  parameter int IDX_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_en,
  input  logic             issue_dir,
  input  logic [IDX_W-1:0] issue_idx,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  localparam int W = IDX_W + 2;

  logic [W-1:0] pipe_r [CORE_LAT];
  logic [W-1:0] tail_s;

  // Shift issue descriptors one stage per cycle; reset drops anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CORE_LAT; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0] <= {issue_en, issue_dir, issue_idx};
      for (int i = 1; i < CORE_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign tail_s = pipe_r[CORE_LAT-1];

  // Split the emerging result by the pass it was issued in; indices read 0 when idle.
  always_comb begin
    wr_en     = tail_s[W-1] & tail_s[W-2];
    out_valid = tail_s[W-1] & ~tail_s[W-2];
    if (wr_en) begin
      wr_idx = tail_s[IDX_W-1:0];
    end else begin
      wr_idx = '0;
    end
    if (out_valid) begin
      out_idx = tail_s[IDX_W-1:0];
    end else begin
      out_idx = '0;
    end
  end

endmodule

// File: rtl/dct2_2d_sequencer.sv
// 2D DCT-II block sequencer.
// Runs one block through the shared 1D core twice: a horizontal pass that
// reads N rows from the source block and writes the results into the
// transpose RAM, then a vertical pass that reads N columns back from the
// transpose RAM and hands the results downstream under dst_ready credit.
// Optional build macro DCT2_SEQ_STALL_CNT_EN adds a stall_cnt output that
// counts vertical-pass cycles lost to missing downstream credit.
module dct2_2d_sequencer
  import dct2_pkg::*;
#(
  parameter int MAX_LOG2 = 5,
  parameter int CORE_LAT = 2,
  parameter int IDX_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       log2_size,
  input  logic             dst_ready,
  output logic             ready,
  output logic             busy,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_idx,
  output logic             direction,
  output logic             mux,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
`ifdef DCT2_SEQ_STALL_CNT_EN
  output logic [15:0]      stall_cnt,
`endif
  output logic             done
);

  // The drain counter only needs to reach CORE_LAT-1.
  localparam int LAT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CORE_LAT - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [IDX_W-1:0] cnt_r;
  logic [IDX_W-1:0] cnt_next_s;
  logic [LAT_W-1:0] lat_r;
  logic [LAT_W-1:0] lat_next_s;
  logic [IDX_W-1:0] last_idx_r;
  logic             accept_s;

  // State, index counter and drain counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      lat_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      lat_r   <= lat_next_s;
    end
  end

  // Capture the last row/column index of the clamped block size on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_idx_r <= '0;
    end else if (accept_s) begin
      last_idx_r <= IDX_W'((32'd1 << clamp_log2(log2_size, 3'(MAX_LOG2))) - 32'd1);
    end else begin
      last_idx_r <= last_idx_r;
    end
  end

  // Next-state logic and per-state issue/control outputs.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    lat_next_s   = lat_r;
    accept_s     = 1'b0;
    ready        = 1'b0;
    rd_en        = 1'b0;
    rd_idx       = '0;
    direction    = 1'b0;
    mux          = 1'b0;
    done         = 1'b0;

    case (state_r)
      IDLE: begin
        ready      = 1'b1;
        direction  = 1'b1;
        cnt_next_s = '0;
        lat_next_s = '0;
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = H;
        end else begin
          state_next_s = IDLE;
        end
      end

      H: begin
        // Source rows issue back to back; downstream credit is irrelevant here.
        direction = 1'b1;
        rd_en     = 1'b1;
        rd_idx    = cnt_r;
        if (cnt_r == last_idx_r) begin
          cnt_next_s   = '0;
          state_next_s = H_DRAIN;
        end else begin
          cnt_next_s = cnt_r + IDX_W'(1);
        end
      end

      H_DRAIN: begin
        // Let the last row result land in the transpose RAM before reading columns.
        direction = 1'b1;
        if (lat_r == LAT_LAST) begin
          lat_next_s   = '0;
          cnt_next_s   = '0;
          state_next_s = V;
        end else begin
          lat_next_s = lat_r + LAT_W'(1);
        end
      end

      V: begin
        // A column issues only with downstream credit; otherwise the index holds.
        mux    = 1'b1;
        rd_en  = dst_ready;
        rd_idx = cnt_r;
        if (dst_ready) begin
          if (cnt_r == last_idx_r) begin
            cnt_next_s   = '0;
            state_next_s = V_DRAIN;
          end else begin
            cnt_next_s = cnt_r + IDX_W'(1);
          end
        end else begin
          cnt_next_s = cnt_r;
        end
      end

      V_DRAIN: begin
        mux = 1'b1;
        if (lat_r == LAT_LAST) begin
          lat_next_s   = '0;
          state_next_s = DONE;
        end else begin
          lat_next_s = lat_r + LAT_W'(1);
        end
      end

      DONE: begin
        done         = 1'b1;
        state_next_s = IDLE;
      end

      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
        lat_next_s   = '0;
      end
    endcase
  end

  assign busy = ~ready;

  dct2_seq_delay #(
    .CORE_LAT (CORE_LAT),
    .IDX_W    (IDX_W)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .issue_en  (rd_en),
    .issue_dir (direction),
    .issue_idx (rd_idx),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .out_valid (out_valid),
    .out_idx   (out_idx)
  );

`ifdef DCT2_SEQ_STALL_CNT_EN
  // Count vertical-pass cycles without downstream credit, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (accept_s) begin
      stall_cnt <= 16'd0;
    end else if ((state_r == V) && !dst_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_dct2_2d_sequencer.sv
// Scoreboard bench for dct2_2d_sequencer (MAX_LOG2=5, CORE_LAT=2).
// The driver computes, per block, the expected issue/write/output/done
// timeline from the block size and the dst_ready pattern it is about to
// apply, and pushes it into queues; a monitor pops and compares.
module tb_dct2_2d_sequencer;

  localparam int L     = 2;
  localparam int IDX_W = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic [2:0]       log2_size;
  logic             dst_ready;
  logic             ready;
  logic             busy;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             direction;
  logic             mux;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             done;
`ifdef DCT2_SEQ_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  dct2_2d_sequencer #(.MAX_LOG2(5), .CORE_LAT(L), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (rst),
    .start     (start),
    .log2_size (log2_size),
    .dst_ready (dst_ready),
    .ready     (ready),
    .busy      (busy),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .direction (direction),
    .mux       (mux),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .out_valid (out_valid),
    .out_idx   (out_idx),
`ifdef DCT2_SEQ_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .done      (done)
  );

  typedef struct { int cyc; int idx; int dir; } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  ev_t out_q[$];
  ev_t done_q[$];   // idx field carries the expected stall count

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int win_c0   = -1;
  int win_v0   = -1;
  int win_d    = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name, input int exp_cyc);
    checks++;
    failures++;
    $display("FAIL %s expected_cycle=%0d actual_cycle=%0d", name, exp_cyc, cyc);
  endfunction

  function automatic int block_n(input int lg);
    if (lg < 2) return 4;
    if (lg > 5) return 32;
    return 1 << lg;
  endfunction

  task automatic check_reset_outputs();
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_direction", direction, 1);
    chk("rst_mux", mux, 0);
    chk("rst_wr", {wr_en, 27'd0, wr_idx}, 0);
    chk("rst_out", {out_valid, 27'd0, out_idx}, 0);
    chk("rst_done", done, 0);
`ifdef DCT2_SEQ_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
  endtask

  // stall_mode: 0 = full credit in V, 1 = credit withheld for V cycles 3..5, 2 = random
  // abort_off > 0: assert reset that many cycles after the accepted start
  task automatic run_block(input int lg, input int stall_mode, input bit hold,
                           input bit poke, input int abort_off);
    int n, c0, v0, k, idx, last, d, stalls, guard;
    bit mask [0:255];
    n = block_n(lg);
    guard = 0;
    while (!ready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ready) fail_now("ready_timeout", cyc);
    c0 = cyc;
    for (int i = 0; i < 256; i++) begin
      if (stall_mode == 0)      mask[i] = 1'b1;
      else if (stall_mode == 1) mask[i] = !(i >= 3 && i < 6);
      else                      mask[i] = ($urandom_range(3) != 0);
    end
    for (int i = 0; i < n; i++) begin
      rd_q.push_back('{cyc: c0 + 1 + i, idx: i, dir: 1});
      wr_q.push_back('{cyc: c0 + 1 + i + L, idx: i, dir: 1});
    end
    v0 = c0 + n + L + 1;
    idx = 0; k = 0; stalls = 0; last = v0;
    while (idx < n) begin
      if (mask[k]) begin
        rd_q.push_back('{cyc: v0 + k, idx: idx, dir: 0});
        out_q.push_back('{cyc: v0 + k + L, idx: idx, dir: 0});
        last = v0 + k;
        idx++;
      end else begin
        stalls++;
      end
      k++;
    end
    d = last + L + 1;
    done_q.push_back('{cyc: d, idx: stalls, dir: 0});
    win_c0 = c0; win_v0 = v0; win_d = d;
    start = 1'b1;
    log2_size = 3'(lg);
    dst_ready = 1'($urandom);
    while (cyc < d) begin
      @(posedge clk); #1;
      if (abort_off > 0 && cyc == c0 + abort_off) begin
        rst = 1'b1;
        #1;
        check_reset_outputs();
        rd_q.delete(); wr_q.delete(); out_q.delete(); done_q.delete();
        win_c0 = -1; win_v0 = -1; win_d = -1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      start = hold ? 1'b1 : (poke && cyc == c0 + 3);
      log2_size = 3'($urandom_range(7));
      if (cyc >= v0 && (cyc - v0) < 256) dst_ready = mask[cyc - v0];
      else dst_ready = 1'($urandom);
    end
    start = hold;
  endtask

  // Monitor: per-cycle control checks plus scoreboard pops on every DUT event.
  initial begin
    ev_t e;
    bit exp_busy;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_busy = (cyc > win_c0) && (cyc <= win_d);
        chk("ready", ready, !exp_busy);
        chk("busy", busy, exp_busy);
        chk("direction", direction, !(cyc >= win_v0 && cyc <= win_d));
        chk("mux", mux, (cyc >= win_v0 && cyc < win_d));
        while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin e = rd_q.pop_front(); fail_now("rd_missing", e.cyc); end
        while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin e = wr_q.pop_front(); fail_now("wr_missing", e.cyc); end
        while (out_q.size() > 0 && out_q[0].cyc < cyc) begin e = out_q.pop_front(); fail_now("out_missing", e.cyc); end
        while (done_q.size() > 0 && done_q[0].cyc < cyc) begin e = done_q.pop_front(); fail_now("done_missing", e.cyc); end
        if (rd_en) begin
          if (rd_q.size() == 0) fail_now("rd_extra", -1);
          else begin
            e = rd_q.pop_front();
            chk("rd_cycle", cyc, e.cyc);
            chk("rd_idx", rd_idx, e.idx);
            chk("rd_dir", direction, e.dir);
          end
        end
        if (wr_en) begin
          if (wr_q.size() == 0) fail_now("wr_extra", -1);
          else begin
            e = wr_q.pop_front();
            chk("wr_cycle", cyc, e.cyc);
            chk("wr_idx", wr_idx, e.idx);
          end
        end
        if (out_valid) begin
          if (out_q.size() == 0) fail_now("out_extra", -1);
          else begin
            e = out_q.pop_front();
            chk("out_cycle", cyc, e.cyc);
            chk("out_idx", out_idx, e.idx);
          end
        end
        if (done) begin
          if (done_q.size() == 0) fail_now("done_extra", -1);
          else begin
            e = done_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
`ifdef DCT2_SEQ_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, e.idx);
`endif
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    log2_size = 3'd0;
    dst_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    @(posedge clk); #1;

    run_block(3, 0, 1'b0, 1'b0, 0);            // N=8 unstalled
    run_block(2, 0, 1'b1, 1'b0, 0);            // N=4 then N=32, start held
    run_block(5, 0, 1'b1, 1'b0, 0);
    start = 1'b0;
    run_block(3, 1, 1'b0, 1'b0, 0);            // three-cycle credit gap mid-V
    run_block(1, 0, 1'b0, 1'b0, 0);            // clamps to 4
    run_block(7, 0, 1'b0, 1'b0, 0);            // clamps to 32
    run_block(4, 0, 1'b0, 1'b0, 22);           // reset during V
    run_block(4, 0, 1'b0, 1'b0, 0);            // full block after abort
    run_block(3, 0, 1'b0, 1'b1, 0);            // start poked during H
    for (int b = 0; b < 6; b++) begin
      run_block(int'($urandom_range(7)), 2, 1'b0, 1'b0, 0);
    end

    start = 1'b0;
    repeat (L + 4) @(posedge clk);
    #1;
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("out_q_empty", out_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
